// File: rtl/mem_arbiter.sv
// Two-requester arbiter giving the I-cache and the D-cache turns on the one main-memory port.
// Optional MEM_ARB_ROUND_ROBIN_EN alternates grants on contention; otherwise the D-cache always has priority.
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_addr,
  output logic [DATA_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic [DATA_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_I = 2'b01,
    GNT_D = 2'b10
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_i_req;
  logic   w_d_req;
  logic   w_pick_d;

  assign w_i_req = i_mem_read;
  assign w_d_req = d_mem_read | d_mem_write;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic r_last_d;

  // Remember who finished the last transfer; reset favours D first
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset)
      r_last_d <= 1'b0;
    else if (mem_ready && r_state == GNT_I)
      r_last_d <= 1'b0;
    else if (mem_ready && r_state == GNT_D)
      r_last_d <= 1'b1;
  end

  assign w_pick_d = w_d_req & (~w_i_req | ~r_last_d);
`else
  assign w_pick_d = w_d_req;
`endif

  // State register
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  // Next state: grant from IDLE, release on ready or abort
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE: begin
        if (w_pick_d)
          w_next = GNT_D;
        else if (w_i_req)
          w_next = GNT_I;
        else
          w_next = IDLE;
      end
      GNT_I: begin
        if (mem_ready || !w_i_req)
          w_next = IDLE;
        else
          w_next = GNT_I;
      end
      GNT_D: begin
        if (mem_ready || !w_d_req)
          w_next = IDLE;
        else
          w_next = GNT_D;
      end
      default: w_next = IDLE;
    endcase
  end

  // Memory-side mux and ready routing from the current grant
  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    i_mem_ready = 1'b0;
    d_mem_ready = 1'b0;
    case (r_state)
      GNT_I: begin
        mem_read    = i_mem_read;
        mem_addr    = i_mem_addr;
        i_mem_ready = mem_ready;
      end
      GNT_D: begin
        mem_write   = d_mem_write;
        mem_read    = d_mem_read & ~d_mem_write;
        mem_addr    = d_mem_addr;
        mem_wdata   = d_mem_wdata;
        d_mem_ready = mem_ready;
      end
      default: ;
    endcase
  end

  assign i_mem_rdata = mem_rdata;
  assign d_mem_rdata = mem_rdata;
  assign busy        = (r_state != IDLE);

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing the single 128-bit main-memory port between the read-only instruction cache and the read/write data cache of the 5-stage RV32 pipeline. It sits between both cache memory interfaces (`mem_read`/`mem_write`/`mem_addr`/`mem_wdata`/`mem_rdata`/`mem_ready`) and the memory model. It grants one requester at a time and holds the grant for a whole block transfer, ending on `mem_ready`. It routes `mem_ready` back only to the granted cache.

## Interface
- `ADDR_W`, 28, block address width (word address >> 2 of 16-byte line)
- `DATA_W`, 128, line width
- `clk`  in  1  clock, all state on rising edge
- `proc_reset`  in  1  asynchronous, active-high reset
- `i_mem_read`  in  1  I-cache block read request
- `i_mem_addr`  in  ADDR_W  I-cache block address
- `i_mem_rdata`  out  DATA_W  line data to I-cache
- `i_mem_ready`  out  1  transfer-done strobe to I-cache
- `d_mem_read`, `d_mem_write`  in  1 each  D-cache read / write-back request
- `d_mem_addr`  in  ADDR_W  D-cache block address
- `d_mem_wdata`  in  DATA_W  D-cache write-back line
- `d_mem_rdata`  out  DATA_W  line data to D-cache
- `d_mem_ready`  out  1  transfer-done strobe to D-cache
- `mem_read`, `mem_write`  out  1 each  to memory
- `mem_addr`  out  ADDR_W  to memory
- `mem_wdata`  out  DATA_W  to memory
- `mem_rdata`  in  DATA_W  from memory
- `mem_ready`  in  1  from memory
- `busy`  out  1  high while any grant is held

## Operation
- FSM states:
  - IDLE (2'b00)
  - GNT_I (2'b01)
  - GNT_D (2'b10)
  - 2'b11 is illegal and recovers to IDLE on the next edge.
- Request signals: `i_req = i_mem_read`; `d_req = d_mem_read | d_mem_write`.
- IDLE transitions:
  - Only d_req → GNT_D.
  - Only i_req → GNT_I.
  - Both → GNT_D (fixed priority; see Configuration).
  - Neither → IDLE.
- GNT_x transitions:
  - `mem_ready` → IDLE.
  - Granted request deasserted before `mem_ready` (abort) → IDLE, and no ready is forwarded.
  - Otherwise hold the grant.
- Memory outputs are combinational from the state and the granted requester's inputs:
  - IDLE: `mem_read=0`, `mem_write=0`, `mem_addr=0`, `mem_wdata=0`.
  - GNT_I: `mem_read=i_mem_read`, `mem_write=0`, `mem_addr=i_mem_addr`, `mem_wdata=0`.
  - GNT_D: all four signals pass through from the D side. If `d_mem_read` and `d_mem_write` are both set, `mem_write` wins and `mem_read` is forced to 0.
- `i_mem_ready = mem_ready & (state==GNT_I)`; `d_mem_ready = mem_ready & (state==GNT_D)`. A `mem_ready` seen in IDLE is ignored.
- `i_mem_rdata` and `d_mem_rdata` are both driven with `mem_rdata` unconditionally. Caches qualify the data with their own ready.
- `busy = (state != IDLE)`.
- Address and data are never modified; widths pass straight through.

## Timing
- Reset (async) forces:
  - state=IDLE
  - `busy=0`
  - all `mem_*` outputs 0
  - both readies 0
  - round-robin pointer = I-last (D favoured first)
- Grant latency: a request asserted in cycle N is visible on the `mem_*` outputs in cycle N+1, provided the arbiter was IDLE in N.
- Ready pass-through is zero-latency and combinational within the same cycle.
- After each `mem_ready` the FSM spends exactly one cycle in IDLE. This guarantees memory sees `mem_read`/`mem_write` low between transfers and gives the cache time to leave its ALLOCATE/WRITEBACK state. Back-to-back transfers are therefore ≥1 idle cycle apart.
- The requester must hold its request and address stable until its ready. The arbiter does not latch the address.
- A losing requester waits with no timeout and is granted on the first IDLE cycle after the current transfer in which it wins arbitration.
- A reset asserted mid-transfer drops the grant immediately. No ready is forwarded for the aborted transfer.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN`:
  - Defined: a 1-bit `last_gnt` register is updated on each completed transfer (`mem_ready` in GNT_x). On a simultaneous request in IDLE, the requester not served last is granted.
  - Undefined: fixed priority, D-cache over I-cache, and no `last_gnt` register is instantiated.
- Single-request behaviour is identical in both builds.

## Test plan
- Reset with both requests high: all outputs 0, `busy=0`. First edge after release: D build grants D, `mem_addr=d_mem_addr`.
- I-cache alone reads addr 0x0000010, memory returns ready after 4 cycles with rdata 0xDEAD…BEEF. Required response:
  - `mem_read=1` for 4 cycles
  - `i_mem_ready=1` for one cycle with `i_mem_rdata` equal to that data
  - `d_mem_ready=0` throughout
  - IDLE in the next cycle
- D write-back (addr 0x0000020, wdata 0x1111…) alongside a pending I read: `mem_write=1`, `mem_read=0` with D data. After ready, 1 idle cycle, then I granted with `mem_addr=i_mem_addr`.
- Both requesters continuously requesting:
  - Without the macro: D served every time, I starved.
  - With `MEM_ARB_ROUND_ROBIN_EN`: grants alternate D, I, D, I.
- D request dropped after 2 cycles of grant: `mem_*` outputs go to 0 the same cycle, state is IDLE next cycle, and a `mem_ready` pulsed then produces no `d_mem_ready`.
- `proc_reset` pulsed mid-GNT_I: `mem_read` drops asynchronously, `busy=0`, and the following `mem_ready` is ignored.
